fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Instruction-fetch stage directly upstream of the unified instruction/data memory.
// - Owns the PC and drives the memory's Read_PC port. Captures the combinational Instruction word it returns.
// - Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
// - Accepts branch/jump redirects (with flush) and halt requests from the control unit.
// PARAMETERS
// - ADDR_W     32    width of PC / Read_PC (word address, NOT byte address)
// - MEM_WORDS  1024  memory depth; PC wraps modulo MEM_WORDS
// - RESET_PC   0     PC value after reset
// - DEPTH      2     FIFO entries (power of 2, >=2)
// PORTS
// - clk          in   1       rising-edge clock
// - rst_n        in   1       asynchronous, active-low reset
// - Read_PC      out  ADDR_W  word address to memory; equals pc_q (registered)
// - Instruction  in   32      memory read data for Read_PC, valid same cycle (combinational)
// - redirect_en  in   1       load redirect_pc, flush FIFO (1-cycle pulse)
// - redirect_pc  in   ADDR_W  redirect target (word address)
// - halt_req     in   1       level; stop fetching while asserted
// - if_valid     out  1       FIFO head valid toward decode
// - if_ready     in   1       decode accepts head this cycle
// - if_instr     out  32      head instruction word
// - if_pc        out  ADDR_W  head instruction address
// - halted       out  1       1 when in HALT state and FIFO empty
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - pc_q=RESET_PC; FIFO empty (count=0); state=RUN.
//   - Outputs: if_valid=0, if_instr=0, if_pc=0, halted=0, Read_PC=RESET_PC.
// - FSM states: RUN, HALT.
//   - RUN->HALT when halt_req=1 and redirect_en=0.
//   - HALT->RUN when halt_req=0 or redirect_en=1.
//   - Redirect has priority over halt_req in every state.
// - pop = if_valid & if_ready.
// - push = state==RUN & !halt_req & !redirect_en & (count<DEPTH | pop).
//   - Full+pop in the same cycle therefore still pushes.
// - On push, at the clock edge:
//   - FIFO tail <= {pc_q, Instruction}.
//   - pc_q <= (pc_q==MEM_WORDS-1) ? 0 : pc_q+1.
// - redirect_en=1, at the clock edge:
//   - FIFO cleared (count=0, a concurrent pop is discarded); no push.
//   - pc_q <= redirect_pc mod MEM_WORDS.
//   - Result: if_valid=0 in the next cycle and the first redirected push lands one cycle later.
//   - Redirect latency: 2 cycles from pulse to if_valid with instr at target.
// - Outputs are driven from FIFO registers only; if_instr/if_pc hold the head while if_valid & !if_ready.
// - Invariant: head is stable until popped.
// - if_valid = count!=0.
// - halted = (state==HALT) & (count==0). Decode drains the FIFO normally while halted.
// - Throughput: 1 instr/cycle when if_ready held high. First if_valid 1 cycle after rst_n release.
// - Width: pc arithmetic in ADDR_W bits; redirect_pc >= MEM_WORDS is reduced modulo MEM_WORDS (never out of range).
// - Reset mid-operation: FIFO contents and state are discarded immediately (asynchronous).
// STRUCTURE
// - fetch_pkg:
//   - fetch_state_t enum {RUN, HALT}.
//   - Constants PC_STEP=1 and FETCH_ENTRY_W=ADDR_W+32.
// - Sub-module fetch_fifo: DEPTH x FETCH_ENTRY_W, with push/pop/flush, count, head outputs.
//   - flush has priority over push/pop.
//   - Unit-testable alone.
// - Top level: pc_q register, FSM, push/wrap logic, fetch_fifo instance.
// TESTING
// - Reset/stream:
//   - Load mem words 0..4 = 0x11,0x22,0x33,0x44,0x55; release rst_n; if_ready=1.
//   - Required: if_valid from cycle 1, if_pc=0,1,2,3,4 with if_instr=0x11..0x55 on consecutive cycles.
// - Backpressure: if_ready=0 for 4 cycles.
//   - Required: FIFO fills to 2 and Read_PC holds at 2.
//   - Required: if_pc=0 / if_instr=0x11 stable throughout; on if_ready=1, 0,1,2 delivered in order with no gap/duplicate.
// - Redirect: pulse redirect_en with redirect_pc=0x3FE while FIFO holds 2 entries.
//   - Required: next cycle if_valid=0; following cycle if_pc=0x3FE.
//   - Required: then 0x3FF, then 0x000 (wrap).
// - Halt: halt_req=1 mid-stream.
//   - Required: Read_PC freezes; the 2 buffered entries drain; halted=1 only after the last pop.
//   - Required: halt_req=0 resumes fetch at the frozen PC.
// - Redirect beats halt: halt_req=1 and redirect_en=1 same cycle, redirect_pc=10.
//   - Required: state RUN, FIFO flushed, if_pc=10 two cycles later.
// - Async reset: assert rst_n=0 mid-clock with FIFO full.
//   - Required: if_valid=0, Read_PC=RESET_PC immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_STEP       = 1;
    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned FETCH_ENTRY_W = DEF_ADDR_W + INSTR_W;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = fetch_pkg::FETCH_ENTRY_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overflow/underflow; a full FIFO may still push when popping.
    always_comb begin
        pop_ok  = pop & (count_q != '0);
        push_ok = push & ((count_q < CNT_W'(DEPTH)) | pop_ok);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures memory data, buffers it toward decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] Read_PC,
    input  logic [31:0]       Instruction,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head;
    logic                push;
    logic                pop;

    assign pop = if_valid & if_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and push decision; redirect overrides halt in both states.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            RUN: begin
                if (halt_req && !redirect_en) begin
                    state_d = HALT;
                end
                push = !halt_req && !redirect_en &&
                       ((count < CNT_W'(DEPTH)) || pop);
            end
            HALT: begin
                if (!halt_req || redirect_en) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Next PC: redirect target reduced into range, else sequential with wrap.
    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = redirect_pc % ADDR_W'(MEM_WORDS);
        end else if (push) begin
            pc_d = (pc_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : pc_q + ADDR_W'(PC_STEP);
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_en),
        .din   ({pc_q, Instruction}),
        .count (count),
        .head  (head)
    );

    assign Read_PC  = pc_q;
    assign if_valid = (count != '0);
    assign if_pc    = head[ENTRY_W-1 -: ADDR_W];
    assign if_instr = head[INSTR_W-1:0];
    assign halted   = (state_q == HALT) && (count == '0);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] Read_PC;
    logic [31:0] Instruction;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    logic [31:0] tb_mem [1024];

    int total = 0;
    int bad   = 0;

    // reference model: pending entries, next fetch address, halt state
    logic [63:0] mq [$];
    int unsigned mpc;
    bit          m_halt;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Read_PC     (Read_PC),
        .Instruction (Instruction),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    assign Instruction = tb_mem[Read_PC[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc    = 0;
        m_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        halt_req    = 1'b0;
        if_ready    = 1'b0;
        #1;
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_read_pc", Read_PC, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic red, input logic [31:0] rpc, input logic hr, input logic rdy);
        logic [63:0] e;
        bit          pop;
        bit          push;
        redirect_en = red;
        redirect_pc = rpc;
        halt_req    = hr;
        if_ready    = rdy;
        @(negedge clk);
        chk("valid", if_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            e = mq[0];
            chk("if_pc", if_pc, e[63:32]);
            chk("if_instr", if_instr, e[31:0]);
        end
        chk("read_pc", Read_PC, mpc);
        chk("halted", halted, (m_halt && mq.size() == 0));
        pop = (mq.size() != 0) && rdy;
        if (red) begin
            mq.delete();
            mpc    = rpc % 1024;
            m_halt = 1'b0;
        end else begin
            push = !m_halt && !hr && (mq.size() < 2 || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({mpc, tb_mem[mpc]});
                mpc = (mpc + 1) % 1024;
            end
            m_halt = hr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_s [5];
        int unsigned frozen;
        logic        hr;
        logic        red;
        logic [31:0] rpc;
        exp_s = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        for (int i = 0; i < 1024; i++) tb_mem[i] = $urandom;
        for (int i = 0; i < 5; i++) tb_mem[i] = exp_s[i];

        rst_n       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        halt_req    = 1'b0;
        if_ready    = 1'b0;
        #2;

        // reset and streaming
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1);
            chk("stream_pc", if_pc, k);
            chk("stream_instr", if_instr, exp_s[k]);
        end

        // backpressure from reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            chk("bp_hold_pc", if_pc, 0);
            chk("bp_hold_instr", if_instr, 32'h11);
        end
        chk("bp_read_pc", Read_PC, 2);
        chk("bp_valid", if_valid, 1);
        step(0, 0, 0, 1);
        chk("bp_drain1", if_pc, 1);
        step(0, 0, 0, 1);
        chk("bp_drain2", if_pc, 2);

        // redirect with full FIFO, then wrap
        step(1, 32'h3FE, 0, 0);
        chk("redir_flush", if_valid, 0);
        step(0, 0, 0, 1);
        chk("redir_tgt", if_pc, 32'h3FE);
        step(0, 0, 0, 1);
        chk("redir_3ff", if_pc, 32'h3FF);
        step(0, 0, 0, 1);
        chk("redir_wrap", if_pc, 0);

        // halt with two buffered entries
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        frozen = mpc;
        step(0, 0, 1, 1);
        chk("halt_rpc1", Read_PC, frozen);
        chk("halt_not_yet", halted, 0);
        step(0, 0, 1, 1);
        chk("halt_rpc2", Read_PC, frozen);
        chk("halt_done", halted, 1);
        step(0, 0, 1, 1);
        chk("halt_rpc3", Read_PC, frozen);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("resume_pc", if_pc, frozen);

        // redirect wins over halt
        step(1, 10, 1, 1);
        chk("rvh_valid", if_valid, 0);
        chk("rvh_halted", halted, 0);
        step(0, 0, 0, 1);
        chk("rvh_pc", if_pc, 10);

        // randomized traffic
        hr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) hr = ~hr;
            red = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1020, 1023));
            step(red, rpc, hr, ($urandom_range(0, 3) != 0));
        end

        // asynchronous reset with a full FIFO
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ar_full", if_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", if_valid, 0);
        chk("ar_read_pc", Read_PC, 0);
        chk("ar_halted", halted, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
